// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: data width, bubble encoding and IF-stage state type.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package rv32_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0 -- the canonical RV32I NOP used as a pipeline bubble
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      FS_REQ,    // request for pc_q presented, waiting for gnt
      FS_WAIT,   // one request outstanding, waiting for rvalid
      FS_VALID,  // instruction parked in the hold register (stalled)
      FS_DRAIN,  // outstanding response belongs to a killed fetch
      FS_HALT    // misaligned redirect target, fetch stopped
   } fetch_state_t;

   // Sequential PC step; wraps modulo 2^XLEN.
   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Holding register for a fetched instruction word plus its valid flag.
// Latency: 1 cycle from load_i to instr_o/valid_o.
// Backpressure: none; load_i has priority over clear_i.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   load_i    capture instr_i and set valid
//   clear_i   drop the held instruction (valid=0, word returns to RST_INSTR)
//   instr_i   instruction word to capture
//   instr_o   held instruction word
//   valid_o   held word is a real instruction
module fetch_hold_reg
   import rv32_pkg::*;
#(
   parameter logic [XLEN-1:0] RST_INSTR = NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] instr_i,
   output logic [XLEN-1:0] instr_o,
   output logic            valid_o
);

   logic [XLEN-1:0] instr_q;
   logic            valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= RST_INSTR;
         valid_q <= 1'b0;
      end else if (load_i) begin
         instr_q <= instr_i;
         valid_q <= 1'b1;
      end else if (clear_i) begin
         instr_q <= RST_INSTR;
         valid_q <= 1'b0;
      end
   end

   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, runs the imem req/gnt/rvalid handshake, feeds IF->DEC.
// Latency: response is presented the same cycle rvalid arrives (bypass); next request issued in that cycle.
// Backpressure: StallF parks the instruction in a hold register and suppresses new requests; at most one request outstanding.
//
// Optional feature macro: FETCH_MISALIGN_EN
//   defined   -> port fetch_misalign; misaligned redirect target halts fetch until an aligned redirect
//   undefined -> no port; redirect target low two bits are ignored
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (shared with imem)
//   StallF                   hold the presented instruction, PC does not advance
//   PCSrcE, PCTargetE        redirect from EX; beats StallF
//   imem_req, imem_addr      request valid / word address (held stable until imem_gnt)
//   imem_gnt                 request accepted this cycle
//   imem_rvalid, imem_rdata  in-order response, earliest the cycle after gnt
//   InstrF, PCF, PCPlus4F    instruction, its PC, PC+4 towards IF->DEC
//   FetchValidF              InstrF/PCF carry a real instruction (else InstrF = NOP_INSTR)
//   fetch_misalign           fetch halted on a misaligned target (FETCH_MISALIGN_EN only)
module if_fetch_unit
   import rv32_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallF,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] InstrF,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPlus4F,
   output logic            FetchValidF
`ifdef FETCH_MISALIGN_EN
   ,
   output logic            fetch_misalign
`endif
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] redirect_pc;
   logic            tgt_misalign;

   logic            req_c;
   logic [XLEN-1:0] addr_c;
   logic            valid_c;
   logic [XLEN-1:0] instr_c;

   logic            hold_load, hold_clear;
   logic [XLEN-1:0] hold_instr;
   logic            hold_vld;

   assign pc_plus4 = pc_inc(pc_q);

`ifdef FETCH_MISALIGN_EN
   assign tgt_misalign = |PCTargetE[1:0];
   assign redirect_pc  = PCTargetE;
`else
   // Without the halt feature a misaligned target is forced onto the word grid.
   assign tgt_misalign = 1'b0;
   assign redirect_pc  = {PCTargetE[XLEN-1:2], 2'b00};
   logic unused_tgt_lo;
   assign unused_tgt_lo = ^PCTargetE[1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FS_REQ;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_c      = 1'b0;
      addr_c     = pc_q;
      valid_c    = 1'b0;
      instr_c    = NOP_INSTR;
      hold_load  = 1'b0;
      hold_clear = 1'b0;

      case (state_q)
         FS_REQ: begin
            // Issue regardless of StallF: the fetch itself does not disturb DEC.
            req_c = 1'b1;
            if (imem_gnt) state_d = FS_WAIT;
         end
         FS_WAIT: begin
            if (imem_rvalid) begin
               valid_c = 1'b1;
               instr_c = imem_rdata;
               if (StallF) begin
                  hold_load = 1'b1;
                  state_d   = FS_VALID;
               end else begin
                  // Consumed this cycle: issue the next sequential fetch immediately.
                  pc_d    = pc_plus4;
                  req_c   = 1'b1;
                  addr_c  = pc_plus4;
                  state_d = imem_gnt ? FS_WAIT : FS_REQ;
               end
            end
         end
         FS_VALID: begin
            valid_c = hold_vld;
            instr_c = hold_instr;
            if (!StallF) begin
               hold_clear = 1'b1;
               pc_d       = pc_plus4;
               req_c      = 1'b1;
               addr_c     = pc_plus4;
               state_d    = imem_gnt ? FS_WAIT : FS_REQ;
            end
         end
         FS_DRAIN: begin
            // The response in flight belongs to a killed fetch; swallow it.
            if (imem_rvalid) state_d = FS_REQ;
         end
         FS_HALT: begin
            state_d = FS_HALT;
         end
         default: begin
            state_d = FS_REQ;
         end
      endcase

      // Redirect overrides everything decided above, including a stall.
      if (PCSrcE) begin
         valid_c    = 1'b0;
         instr_c    = NOP_INSTR;
         req_c      = 1'b0;
         addr_c     = pc_q;
         hold_load  = 1'b0;
         hold_clear = 1'b1;
         pc_d       = redirect_pc;
         if (tgt_misalign)
            state_d = FS_HALT;
         else if (state_q == FS_DRAIN)
            state_d = imem_rvalid ? FS_REQ : FS_DRAIN;
         else if (state_q == FS_WAIT && !imem_rvalid)
            state_d = FS_DRAIN;
         else
            state_d = FS_REQ;
      end
   end

   fetch_hold_reg #(
      .RST_INSTR (NOP_INSTR)
   ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load_i  (hold_load),
      .clear_i (hold_clear),
      .instr_i (instr_c),
      .instr_o (hold_instr),
      .valid_o (hold_vld)
   );

   // Reset gates the combinational outputs so nothing leaks out while rst is high.
   assign imem_req    = req_c & ~rst;
   assign imem_addr   = addr_c;
   assign FetchValidF = valid_c & ~rst;
   assign InstrF      = FetchValidF ? instr_c : NOP_INSTR;
   assign PCF         = pc_q;
   assign PCPlus4F    = pc_plus4;

`ifdef FETCH_MISALIGN_EN
   assign fetch_misalign = (state_q == FS_HALT);
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios plus a randomized run against a program-order model.
// Latency: n/a.
// Backpressure: the bench's imem model grants randomly and answers in order after 1..N cycles.
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        StallF = 1'b0, PCSrcE = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] PCTargetE = '0, imem_rdata = '0;
   logic        imem_req, FetchValidF;
   logic [31:0] imem_addr, InstrF, PCF, PCPlus4F;
`ifdef FETCH_MISALIGN_EN
   logic        fetch_misalign;
`endif

   if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .FetchValidF(FetchValidF)
`ifdef FETCH_MISALIGN_EN
      , .fetch_misalign(fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // imem model: one outstanding slot, response after out_cnt further cycles
   bit          out_vld = 1'b0;
   logic [31:0] out_addr = '0;
   int          out_cnt = 0;
   int          lat_lo = 0, lat_hi = 0;
   // program-order model: PC the stage must currently be presenting
   logic [31:0] exp_pc = RST_PC;

   // samples taken #1 after inputs are driven
   logic        s_req, s_vld, s_rvalid, s_mis;
   logic [31:0] s_addr, s_instr, s_pc, s_pc4;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] redir_pc(input logic [31:0] t);
`ifdef FETCH_MISALIGN_EN
      return t;
`else
      return t & ~32'h3;
`endif
   endfunction

   // Called at a negedge: drive this cycle's inputs, let them settle, sample outputs.
   task automatic step_drive(input logic st, input logic rd, input logic [31:0] tg, input logic g);
      StallF = st; PCSrcE = rd; PCTargetE = tg; imem_gnt = g;
      if (out_vld && out_cnt == 0) begin
         imem_rvalid = 1'b1; imem_rdata = mem(out_addr);
      end else begin
         imem_rvalid = 1'b0; imem_rdata = $urandom;
         if (out_vld) out_cnt--;
      end
      #1;
      s_req = imem_req; s_addr = imem_addr; s_vld = FetchValidF; s_instr = InstrF;
      s_pc = PCF; s_pc4 = PCPlus4F; s_rvalid = imem_rvalid;
`ifdef FETCH_MISALIGN_EN
      s_mis = fetch_misalign;
`else
      s_mis = 1'b0;
`endif
   endtask

   // Advance across the posedge, update the imem and program-order models, return at the negedge.
   task automatic step_commit();
      @(posedge clk);
      if (imem_rvalid) out_vld = 1'b0;
      if (s_req && imem_gnt) begin
         out_vld = 1'b1; out_addr = s_addr; out_cnt = $urandom_range(lat_hi, lat_lo);
      end
      if (PCSrcE) exp_pc = redir_pc(PCTargetE);
      else if (s_vld && !StallF) exp_pc = exp_pc + 32'd4;
      @(negedge clk);
   endtask

   task automatic step(input logic st, input logic rd, input logic [31:0] tg, input logic g);
      step_drive(st, rd, tg, g);
      step_commit();
   endtask

   task automatic do_reset();
      rst = 1'b1; StallF = 0; PCSrcE = 0; PCTargetE = '0; imem_gnt = 0; imem_rvalid = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; out_vld = 1'b0; exp_pc = RST_PC; lat_lo = 0; lat_hi = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0 || FetchValidF !== 1'b0) begin bad++;
         $display("FAIL reset_in_cycle req=%b vld=%b need 0/0", imem_req, FetchValidF); end
      @(posedge clk); #1;
      total++; if (PCF !== RST_PC || PCPlus4F !== RST_PC + 32'd4) begin bad++;
         $display("FAIL reset_pc pc=%h pc4=%h need %h/%h", PCF, PCPlus4F, RST_PC, RST_PC + 32'd4); end
      total++; if (InstrF !== NOP || FetchValidF !== 1'b0 || imem_req !== 1'b0) begin bad++;
         $display("FAIL reset_outs instr=%h vld=%b req=%b need %h/0/0", InstrF, FetchValidF, imem_req, NOP); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; out_vld = 1'b0; exp_pc = RST_PC;
   endtask

   // gnt every cycle, response one cycle later: back-to-back fetch
   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         logic [31:0] a, p;
         a = RST_PC + 32'(4 * i);
         p = RST_PC + 32'(4 * (i - 1));
         step_drive(0, 0, '0, 1);
         total++; if (s_req !== 1'b1 || s_addr !== a) begin bad++;
            $display("FAIL stream_addr[%0d] req=%b addr=%h need 1/%h", i, s_req, s_addr, a); end
         if (i > 0) begin
            total++; if (s_vld !== 1'b1 || s_pc !== p || s_instr !== mem(p)) begin bad++;
               $display("FAIL stream_out[%0d] vld=%b pc=%h instr=%h need 1/%h/%h", i, s_vld, s_pc, s_instr, p, mem(p)); end
         end
         step_commit();
      end
   endtask

   task automatic test_stall();
      do_reset();
      repeat (3) step(0, 0, '0, 1);
      for (int i = 0; i < 3; i++) begin
         step_drive(1, 0, '0, 1);
         total++; if (s_vld !== 1'b1 || s_pc !== 32'h8 || s_instr !== mem(32'h8) || s_req !== 1'b0) begin bad++;
            $display("FAIL stall_hold[%0d] vld=%b pc=%h instr=%h req=%b need 1/8/%h/0", i, s_vld, s_pc, s_instr, s_req, mem(32'h8)); end
         step_commit();
      end
      step_drive(0, 0, '0, 1);
      total++; if (s_vld !== 1'b1 || s_pc !== 32'h8 || s_req !== 1'b1 || s_addr !== 32'hC) begin bad++;
         $display("FAIL stall_release vld=%b pc=%h req=%b addr=%h need 1/8/1/c", s_vld, s_pc, s_req, s_addr); end
      step_commit();
      step_drive(0, 0, '0, 1);
      total++; if (s_vld !== 1'b1 || s_pc !== 32'hC || s_instr !== mem(32'hC)) begin bad++;
         $display("FAIL stall_next vld=%b pc=%h instr=%h need 1/c/%h", s_vld, s_pc, s_instr, mem(32'hC)); end
      step_commit();
   endtask

   task automatic test_redirect_drain();
      bit found;
      do_reset();
      repeat (4) step(0, 0, '0, 1);
      lat_lo = 2; lat_hi = 2;
      step(0, 0, '0, 1);                  // issues 0x10, response two cycles out
      lat_lo = 0; lat_hi = 0;
      step_drive(0, 1, 32'h100, 0);
      total++; if (s_vld !== 1'b0 || s_req !== 1'b0) begin bad++;
         $display("FAIL drain_redirect vld=%b req=%b need 0/0", s_vld, s_req); end
      step_commit();
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         step_drive(0, 0, '0, 1);
         if (s_req === 1'b1) found = 1'b1;
         else begin
            total++; if (s_vld !== 1'b0) begin bad++;
               $display("FAIL drain_stale vld=%b instr=%h need 0", s_vld, s_instr); end
            step_commit();
         end
      end
      total++; if (!found || s_addr !== 32'h100) begin bad++;
         $display("FAIL drain_next_req req=%b addr=%h need 1/100", s_req, s_addr); end
      step_commit();
      step_drive(0, 0, '0, 1);
      total++; if (s_vld !== 1'b1 || s_pc !== 32'h100 || s_instr !== mem(32'h100)) begin bad++;
         $display("FAIL drain_target vld=%b pc=%h instr=%h need 1/100/%h", s_vld, s_pc, s_instr, mem(32'h100)); end
      step_commit();
   endtask

   task automatic test_redirect_stall();
      do_reset();
      repeat (3) step(0, 0, '0, 1);
      step_drive(1, 1, 32'h200, 1);
      total++; if (s_vld !== 1'b0 || s_req !== 1'b0) begin bad++;
         $display("FAIL redir_stall vld=%b req=%b need 0/0", s_vld, s_req); end
      step_commit();
      step_drive(1, 0, '0, 1);
      total++; if (s_req !== 1'b1 || s_addr !== 32'h200 || s_vld !== 1'b0) begin bad++;
         $display("FAIL redir_stall_req req=%b addr=%h vld=%b need 1/200/0", s_req, s_addr, s_vld); end
      step_commit();
      step_drive(1, 0, '0, 1);
      total++; if (s_vld !== 1'b1 || s_pc !== 32'h200 || s_instr !== mem(32'h200)) begin bad++;
         $display("FAIL redir_stall_out vld=%b pc=%h instr=%h need 1/200/%h", s_vld, s_pc, s_instr, mem(32'h200)); end
      step_commit();
   endtask

   task automatic test_gnt_low();
      do_reset();
      step(0, 0, '0, 1);
      step(0, 0, '0, 0);                  // consumes 0x0, request for 0x4 not granted
      for (int i = 0; i < 4; i++) begin
         step_drive(0, 0, '0, 0);
         total++; if (s_req !== 1'b1 || s_addr !== 32'h4 || s_vld !== 1'b0 || s_instr !== NOP) begin bad++;
            $display("FAIL gnt_low[%0d] req=%b addr=%h vld=%b instr=%h need 1/4/0/%h", i, s_req, s_addr, s_vld, s_instr, NOP); end
         step_commit();
      end
      step(0, 0, '0, 1);
      step_drive(0, 0, '0, 1);
      total++; if (s_vld !== 1'b1 || s_pc !== 32'h4 || s_instr !== mem(32'h4)) begin bad++;
         $display("FAIL gnt_low_after vld=%b pc=%h instr=%h need 1/4/%h", s_vld, s_pc, s_instr, mem(32'h4)); end
      step_commit();
   endtask

   task automatic test_wrap();
      do_reset();
      step(0, 1, 32'hFFFF_FFFC, 1);
      step_drive(0, 0, '0, 1);
      total++; if (s_addr !== 32'hFFFF_FFFC || s_pc4 !== 32'h0) begin bad++;
         $display("FAIL wrap_req addr=%h pc4=%h need fffffffc/0", s_addr, s_pc4); end
      step_commit();
      step_drive(0, 0, '0, 1);
      total++; if (s_vld !== 1'b1 || s_instr !== mem(32'hFFFF_FFFC) || s_req !== 1'b1 || s_addr !== 32'h0) begin bad++;
         $display("FAIL wrap_next vld=%b instr=%h req=%b addr=%h need 1/%h/1/0", s_vld, s_instr, s_req, s_addr, mem(32'hFFFF_FFFC)); end
      step_commit();
      step_drive(0, 0, '0, 1);
      total++; if (s_pc !== 32'h0 || s_instr !== mem(32'h0)) begin bad++;
         $display("FAIL wrap_zero pc=%h instr=%h need 0/%h", s_pc, s_instr, mem(32'h0)); end
      step_commit();
   endtask

   task automatic test_misalign();
      do_reset();
      step(0, 0, '0, 1);
`ifdef FETCH_MISALIGN_EN
      step(0, 1, 32'h102, 1);
      for (int i = 0; i < 4; i++) begin
         step_drive(0, 0, '0, 1);
         total++; if (s_mis !== 1'b1 || s_req !== 1'b0 || s_vld !== 1'b0) begin bad++;
            $display("FAIL misalign_halt[%0d] mis=%b req=%b vld=%b need 1/0/0", i, s_mis, s_req, s_vld); end
         step_commit();
      end
      step(0, 1, 32'h200, 1);
      step_drive(0, 0, '0, 1);
      total++; if (s_mis !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h200) begin bad++;
         $display("FAIL misalign_resume mis=%b req=%b addr=%h need 0/1/200", s_mis, s_req, s_addr); end
      step_commit();
`else
      step(0, 1, 32'h102, 1);
      step_drive(0, 0, '0, 1);
      total++; if (s_req !== 1'b1 || s_addr !== 32'h100 || s_pc !== 32'h100 || s_mis !== 1'b0) begin bad++;
         $display("FAIL misalign_mask req=%b addr=%h pc=%h need 1/100/100", s_req, s_addr, s_pc); end
      step_commit();
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      lat_lo = 2; lat_hi = 2;
      step(0, 0, '0, 1);
      step(0, 0, '0, 0);
      rst = 1'b1; StallF = 0; PCSrcE = 0; imem_gnt = 1; imem_rvalid = 0;
      #1;
      total++; if (imem_req !== 1'b0 || FetchValidF !== 1'b0 || InstrF !== NOP) begin bad++;
         $display("FAIL rst_mid_in req=%b vld=%b instr=%h need 0/0/%h", imem_req, FetchValidF, InstrF, NOP); end
      @(posedge clk); #1;
      total++; if (PCF !== RST_PC || PCPlus4F !== RST_PC + 32'd4 || imem_req !== 1'b0 || FetchValidF !== 1'b0) begin bad++;
         $display("FAIL rst_mid_after pc=%h pc4=%h req=%b vld=%b need %h/%h/0/0", PCF, PCPlus4F, imem_req, FetchValidF, RST_PC, RST_PC + 32'd4); end
      @(negedge clk);
      rst = 1'b0; out_vld = 1'b0; exp_pc = RST_PC; lat_lo = 0; lat_hi = 0;
      step_drive(0, 0, '0, 1);
      total++; if (s_req !== 1'b1 || s_addr !== RST_PC || s_vld !== 1'b0) begin bad++;
         $display("FAIL rst_mid_req req=%b addr=%h vld=%b need 1/%h/0", s_req, s_addr, s_vld, RST_PC); end
      step_commit();
      step_drive(0, 0, '0, 1);
      total++; if (s_vld !== 1'b1 || s_pc !== RST_PC || s_instr !== mem(RST_PC)) begin bad++;
         $display("FAIL rst_mid_first vld=%b pc=%h instr=%h need 1/%h/%h", s_vld, s_pc, s_instr, RST_PC, mem(RST_PC)); end
      step_commit();
   endtask

   // Random stalls, grants, latencies and redirects against the program-order model.
   task automatic test_random();
      int n_cons;
      bit p_pend, p_hold;
      n_cons = 0; p_pend = 0; p_hold = 0;
      do_reset();
      lat_lo = 0; lat_hi = 3;
      for (int i = 0; i < 600; i++) begin
         logic st, rd, g, cons;
         logic [31:0] tg, ea;
         st = ($urandom_range(99, 0) < 30);
         rd = ($urandom_range(99, 0) < 6);
         g  = ($urandom_range(99, 0) < 65);
         tg = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFF);
`ifdef FETCH_MISALIGN_EN
         tg = tg & ~32'h3;
`endif
         step_drive(st, rd, tg, g);
         cons = s_vld && !st && !rd;
         ea = cons ? exp_pc + 32'd4 : exp_pc;
         total++; if (s_pc !== exp_pc || s_pc4 !== exp_pc + 32'd4) begin bad++;
            $display("FAIL rnd_pc[%0d] pc=%h pc4=%h need %h/%h", i, s_pc, s_pc4, exp_pc, exp_pc + 32'd4); end
         total++; if (s_instr !== (s_vld ? mem(exp_pc) : NOP)) begin bad++;
            $display("FAIL rnd_instr[%0d] vld=%b instr=%h need %h", i, s_vld, s_instr, s_vld ? mem(exp_pc) : NOP); end
         if (rd) begin
            total++; if (s_vld !== 1'b0 || s_req !== 1'b0) begin bad++;
               $display("FAIL rnd_redirect[%0d] vld=%b req=%b need 0/0", i, s_vld, s_req); end
         end
         if (s_req) begin
            total++; if (s_addr !== ea) begin bad++;
               $display("FAIL rnd_addr[%0d] addr=%h need %h", i, s_addr, ea); end
            total++; if (out_vld && !s_rvalid) begin bad++;
               $display("FAIL rnd_outstanding[%0d] req=1 with pending response for %h", i, out_addr); end
         end
         if (p_pend && !rd) begin
            total++; if (s_req !== 1'b1) begin bad++;
               $display("FAIL rnd_req_drop[%0d] req=%b need 1", i, s_req); end
         end
         if (p_hold && !rd) begin
            total++; if (s_vld !== 1'b1) begin bad++;
               $display("FAIL rnd_hold[%0d] vld=%b need 1", i, s_vld); end
         end
         if (cons) n_cons++;
         p_pend = s_req && !g;
         p_hold = s_vld && st && !rd;
         step_commit();
      end
      total++; if (n_cons < 40) begin bad++;
         $display("FAIL rnd_progress consumed=%0d need >=40", n_cons); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drain();
      test_redirect_stall();
      test_gnt_low();
      test_wrap();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
